// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the MULT/MULTU/DIV/DIVU sequencer.
//   op_e    - operation encoding as presented on muldiv_seq.op
//   state_e - sequencer FSM states
//   ITERS_DEF - default iteration count (one step per operand bit)
//   DIV0_LO   - quotient reported for a divide by zero
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam int          ITERS_DEF = 32;
    localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

    // Bit 1 of the encoding selects divide, bit 0 selects signed.
    function automatic logic op_is_div(input op_e o);
        return o[1];
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return o[0];
    endfunction

endpackage

// File: rtl/step_addsub33.sv
// step_addsub33: combinational 33-bit add/subtract shared by the multiply
// and divide iterations.
//   x, y : 33-bit operands
//   sub  : 1 = x - y, 0 = x + y
//   sum  : 33-bit result (bit 32 is the carry for add, the sign for subtract)
//   neg  : bit 32 of the result; for a subtract of non-negative operands
//          this is the "trial went negative" flag
module step_addsub33 (
    input  logic [32:0] x,
    input  logic [32:0] y,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        neg
);

    always_comb begin
        sum = sub ? (x - y) : (x + y);
        neg = sum[32];
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU unit (shift-add multiply,
// restoring divide) with a fixed 35-cycle latency from the accepting edge.
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   start    - request, accepted in IDLE or DONE only
//   op       - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b     - rs / rt operands, sampled on the accepting edge
//   busy     - high in PREP, ITER and FIX
//   done     - one-cycle pulse in DONE
//   hi, lo   - product halves, or remainder / quotient
//   div_zero - divide with b == 0; held with hi/lo
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = ITERS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(ITERS + 1);
    localparam int AW    = 2 * WIDTH;

    // Conditional two's-complement negation.
    function automatic logic [WIDTH-1:0] cneg_w(input logic signed [WIDTH-1:0] v,
                                                input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [AW-1:0] cneg_2w(input logic signed [AW-1:0] v,
                                              input logic en);
        return en ? -v : v;
    endfunction

    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt;

    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
    logic [AW-1:0]    acc;       // {hi, lo} product or {rem, quot}
    logic             neg_q;     // negate product / quotient
    logic             neg_r;     // negate remainder

    logic             accept;
    logic             is_div, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [AW-1:0]    prep_acc, iter_acc, prod;
    logic [WIDTH-1:0] prep_opnd;
    logic [WIDTH:0]   add_x, add_y, add_sum;
    logic             add_neg;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic             fix_dz;

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign busy   = (state == S_PREP) || (state == S_ITER) || (state == S_FIX);
    assign done   = (state == S_DONE);

    // ---- FSM next state ----
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_PREP;
            S_PREP:  state_nx = S_ITER;
            S_ITER:  if (cnt == CNT_W'(1)) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = start ? S_PREP : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ---- PREP: operand magnitudes and result signs ----
    always_comb begin
        is_div    = op_is_div(op_q);
        sa        = op_is_signed(op_q) & a_q[WIDTH-1];
        sb        = op_is_signed(op_q) & b_q[WIDTH-1];
        // 0x8000_0000 negates to itself, which is the correct unsigned magnitude.
        mag_a     = cneg_w(a_q, sa);
        mag_b     = cneg_w(b_q, sb);
        // Multiply keeps the multiplier in the low half and shifts it out LSB
        // first; divide keeps the dividend there and shifts it out MSB first.
        prep_acc  = is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        prep_opnd = is_div ? mag_b : mag_a;
    end

    // ---- ITER: one add/sub step ----
    always_comb begin
        // Divide sees the remainder already shifted left by one, so its top
        // bit lands in bit 32 of the step input.
        add_x = is_div ? acc[AW-1:WIDTH-1] : {1'b0, acc[AW-1:WIDTH]};
        add_y = {1'b0, opnd};
    end

    step_addsub33 u_step (
        .x   (add_x),
        .y   (add_y),
        .sub (is_div),
        .sum (add_sum),
        .neg (add_neg)
    );

    always_comb begin
        if (is_div) begin
            if (add_neg)
                iter_acc = {add_x[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                iter_acc = {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            // Shift the 65-bit {carry, upper, lower} right by one.
            if (acc[0])
                iter_acc = {add_sum, acc[WIDTH-1:1]};
            else
                iter_acc = {add_x, acc[WIDTH-1:1]};
        end
    end

    // ---- FIX: sign correction and divide-by-zero override ----
    always_comb begin
        prod   = cneg_2w(acc, neg_q);
        fix_hi = prod[AW-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        fix_dz = 1'b0;
        if (is_div) begin
            if (b_q == '0) begin
                fix_hi = a_q;
                fix_lo = DIV0_LO;
                fix_dz = 1'b1;
            end else begin
                fix_lo = cneg_w(acc[WIDTH-1:0], neg_q);
                fix_hi = cneg_w(acc[AW-1:WIDTH], neg_r);
            end
        end
    end

    // ---- control and result registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_PREP)
                cnt <= CNT_W'(ITERS);
            else if (state == S_ITER)
                cnt <= cnt - CNT_W'(1);
            if (state == S_FIX) begin
                hi       <= fix_hi;
                lo       <= fix_lo;
                div_zero <= fix_dz;
            end
        end
    end

    // ---- datapath registers (no reset; qualified by state) ----
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op_e'(op);
            a_q  <= a;
            b_q  <= b;
        end
        if (state == S_PREP) begin
            acc   <= prep_acc;
            opnd  <= prep_opnd;
            neg_q <= sa ^ sb;
            neg_r <= is_div & sa;
        end else if (state == S_ITER) begin
            acc <= iter_acc;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed-vector bench for muldiv_seq with hand-computed
// results, latency and busy-window checks, mid-op start, back-to-back issue
// and reset-in-flight.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request; called at a falling edge so the next rising edge samples it.
    task automatic issue(input op_e o, input logic [31:0] av, input logic [31:0] bv);
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
    endtask

    // Waits for the accepting edge, then follows the operation to its done
    // pulse. ign_cyc > 0 pulses start with unrelated operands in that cycle.
    // Returns at the falling edge of the DONE cycle.
    task automatic run_op(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int ign_cyc);
        int busy_cnt;
        bit seen;
        busy_cnt = 0;
        seen     = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check({tag, "_latency"}, c, 35);
                check({tag, "_busy_cycles"}, busy_cnt, 34);
                check({tag, "_busy_at_done"}, busy, 0);
                check({tag, "_hi"}, hi, ehi);
                check({tag, "_lo"}, lo, elo);
                check({tag, "_div_zero"}, div_zero, edz);
            end else begin
                if (busy) busy_cnt++;
                if (c == ign_cyc) begin
                    op    = OP_DIVU;
                    a     = 32'd7;
                    b     = 32'd3;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int seen_cnt;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_div_zero", div_zero, 0);
        rst_n = 1'b1;

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        run_op("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
        @(negedge clk);

        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        run_op("mult_minmin", 32'h4000_0000, 32'h0, 1'b0, 0);
        @(negedge clk);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        @(negedge clk);

        issue(OP_DIVU, 32'd100, 32'd7);
        run_op("divu_100_7", 32'd2, 32'd14, 1'b0, 0);
        @(negedge clk);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_ovf", 32'h0, 32'h8000_0000, 1'b0, 0);
        @(negedge clk);

        issue(OP_DIVU, 32'd5, 32'd0);
        run_op("divu_zero", 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
        @(negedge clk);

        issue(OP_DIV, 32'hFFFF_FFF7, 32'd0);
        run_op("div_zero_neg", 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 0);
        @(negedge clk);

        // start pulsed mid-operation must be ignored
        issue(OP_DIVU, 32'd1000, 32'd10);
        run_op("ignore_start", 32'd0, 32'd100, 1'b0, 10);
        @(negedge clk);

        // Back-to-back: second request presented in the DONE cycle
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        run_op("b2b_first", 32'h1, 32'h0, 1'b0, 0);
        issue(OP_DIV, 32'd20, 32'hFFFF_FFFA);
        run_op("b2b_second", 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
        @(negedge clk);

        // Reset in cycle 20 of a divide, with start asserted during reset
        issue(OP_DIV, 32'd100, 32'd7);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        issue(OP_MULTU, 32'd3, 32'd3);
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_div_zero", div_zero, 0);
        rst_n = 1'b1;
        start = 1'b0;
        seen_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen_cnt++;
        end
        check("midrst_quiet", seen_cnt, 0);

        issue(OP_MULTU, 32'd6, 32'd7);
        run_op("after_rst", 32'd0, 32'd42, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
